pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning max data-memory wait cycles before error (range 2..255).
REQ-002 Parameter CNT_W, default 32, meaning width of each performance counter.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; reset asserted when low.
REQ-005 Rs1D, Rs2D  in  5  ID-stage source registers.
REQ-006 Rs1E, Rs2E, RdE  in  5  EX-stage source/destination registers.
REQ-007 RdM, RdW  in  5  MEM/WB destination registers.
REQ-008 RegWriteM, RegWriteW  in  1  MEM/WB register-write enables.
REQ-009 ResultSrcE  in  2  EX result select; 2'b01 marks a load.
REQ-010 PCSrcE  in  1  taken branch/jump resolved in EX.
REQ-011 MemReqM  in  1  load or store occupying MEM.
REQ-012 MemAckM  in  1  data memory completes MEM access this cycle.
REQ-013 perf_clr  in  1  synchronous clear of all performance counters.
REQ-014 ForwardAE, ForwardBE  out  2  EX operand select: 00 register file, 01 WB result, 10 MEM ALU result.
REQ-015 StallF, StallD, StallE, StallM  out  1  hold corresponding pipeline register.
REQ-016 FlushD, FlushE, FlushW  out  1  load bubble into IF/ID, ID/EX, MEM/WB.
REQ-017 mem_err  out  1  sticky data-memory timeout flag.
REQ-018 state  out  2  FSM state: 00 RUN, 01 MEMWAIT, 10 ERR.
REQ-019 cyc_cnt, stall_cnt, flush_cnt  out  CNT_W  performance counters.

Function
REQ-020 Forwarding is combinational: ForwardAE SHALL be 10 when RegWriteM, RdM!=0, RdM==Rs1E; else 01 when RegWriteW, RdW!=0, RdW==Rs1E; else 00; ForwardBE identical using Rs2E.
REQ-021 lwStall SHALL be ResultSrcE==01 and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
REQ-022 freeze SHALL be (state==RUN and MemReqM and !MemAckM) or (state==MEMWAIT and !MemAckM) or state==ERR.
REQ-023 When freeze: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0 (flush deferred; PCSrcE held by stalled EX).
REQ-024 When not freeze: StallF=StallD=lwStall, StallE=StallM=FlushW=0, FlushD=PCSrcE, FlushE=lwStall or PCSrcE.
REQ-025 FSM RUN->MEMWAIT when MemReqM and !MemAckM; MemReqM with MemAckM same cycle causes no stall and no transition.
REQ-026 MEMWAIT->RUN on MemAckM; wait counter SHALL clear on entry to RUN.
REQ-027 Wait counter (8-bit) increments each MEMWAIT cycle without ack; reaching TIMEOUT-1 without ack SHALL transition to ERR next edge.
REQ-028 ERR is absorbing until reset; mem_err=1 in ERR, 0 otherwise; ack in ERR ignored.
REQ-029 cyc_cnt increments every cycle; stall_cnt increments each cycle StallF=1; flush_cnt increments each cycle FlushD=1.
REQ-030 Counters SHALL saturate at all-ones, not wrap.
REQ-031 perf_clr SHALL zero all counters next edge, overriding a same-cycle increment; FSM unaffected.

Reset
REQ-032 reset low SHALL immediately force state=RUN, wait counter=0, all counters=0, mem_err=0, regardless of clk.
REQ-033 Combinational outputs SHALL follow REQ-020..024 during reset using state=RUN.
REQ-034 reset assertion mid-MEMWAIT or in ERR SHALL abandon the access; first edge after release evaluates RUN rules.

Verification
REQ-035 RdM=5,RegWriteM=1,RdW=5,RegWriteW=1,Rs1E=5,Rs2E=0 -> ForwardAE=10, ForwardBE=00; RdM=0 case -> ForwardAE=01.
REQ-036 ResultSrcE=01,RdE=7,Rs2D=7, MemReqM=0 -> StallF=StallD=1, FlushE=1, FlushD=0, stall_cnt +1 per cycle.
REQ-037 MemReqM=1, MemAckM low 3 cycles then high -> state RUN,MEMWAIT,MEMWAIT,MEMWAIT,RUN; all stalls and FlushW high 3 cycles; simultaneous PCSrcE=1 yields FlushD=1 only after ack.
REQ-038 TIMEOUT=4, MemReqM=1, MemAckM=0 held -> ERR after 4 wait cycles, mem_err=1 and freeze persist; later ack no effect; reset low clears to RUN.
REQ-039 perf_clr=1 in cycle with StallF=1 and FlushD=1 -> all counters 0 next edge; counters preloaded near max saturate at all-ones.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for a 5-stage pipeline: operand forwarding, load-use
// interlock, branch flush, data-memory wait/timeout FSM and saturating perf counters.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemAckM,
  input  logic             perf_clr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_MEMWAIT = 2'b01,
    ST_ERR     = 2'b10
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_r;
  logic [7:0]       wait_cnt_r;
  logic             mem_err_r;
  logic [CNT_W-1:0] cyc_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             lw_stall_s;
  logic             freeze_s;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic we_m, input logic [4:0] rd_w,
                                         input logic we_w);
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      fwd_sel = 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      fwd_sel = 2'b01;
    end else begin
      fwd_sel = 2'b00;
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Forwarding selects and hazard detection terms
  always_comb begin
    ForwardAE  = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE  = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    lw_stall_s = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    freeze_s   = ((state_r == ST_RUN) && MemReqM && !MemAckM) ||
                 ((state_r == ST_MEMWAIT) && !MemAckM) ||
                 (state_r == ST_ERR);
  end

  // Stall/flush steering; a pending branch flush waits until the memory freeze lifts
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (freeze_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall_s;
      StallD = lw_stall_s;
      FlushD = PCSrcE;
      FlushE = lw_stall_s || PCSrcE;
    end
  end

  // Data-memory wait FSM with timeout into an absorbing error state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= 8'd0;
      mem_err_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          wait_cnt_r <= 8'd0;
          if (MemReqM && !MemAckM) begin
            state_r <= ST_MEMWAIT;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_MEMWAIT: begin
          if (MemAckM) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= 8'd0;
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r   <= ST_ERR;
            mem_err_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        ST_ERR: begin
          state_r   <= ST_ERR;
          mem_err_r <= 1'b1;
        end
        default: begin
          // Unreachable encoding: fail safe into the error state
          state_r   <= ST_ERR;
          mem_err_r <= 1'b1;
        end
      endcase
    end
  end

  // Saturating performance counters with synchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt_r   <= {CNT_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (perf_clr) begin
      cyc_cnt_r   <= {CNT_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      cyc_cnt_r <= sat_inc(cyc_cnt_r);
      if (StallF) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (FlushD) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign state     = state_r;
  assign mem_err   = mem_err_r;
  assign cyc_cnt   = cyc_cnt_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (TIMEOUT=4, 8-bit counters so
// saturation is reachable in a short run).
module tb_pipeline_ctrl;

  localparam int CW = 8;

  logic          clk;
  logic          reset;
  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW;
  logic [1:0]    ResultSrcE;
  logic          PCSrcE, MemReqM, MemAckM, perf_clr;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushW;
  logic          mem_err;
  logic [1:0]    state;
  logic [CW-1:0] cyc_cnt, stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
    .MemAckM(MemAckM), .perf_clr(perf_clr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .mem_err(mem_err), .state(state),
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
    RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = 2'b00; PCSrcE = 1'b0; MemReqM = 1'b0; MemAckM = 1'b0;
    perf_clr = 1'b0;
  endtask

  task automatic clr_counters();
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
  endtask

  task automatic check_freeze(input string tag, input logic exp);
    check({tag, "_stallF"}, {31'd0, StallF}, {31'd0, exp});
    check({tag, "_stallD"}, {31'd0, StallD}, {31'd0, exp});
    check({tag, "_stallE"}, {31'd0, StallE}, {31'd0, exp});
    check({tag, "_stallM"}, {31'd0, StallM}, {31'd0, exp});
    check({tag, "_flushW"}, {31'd0, FlushW}, {31'd0, exp});
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    #3;
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_memerr", {31'd0, mem_err}, 32'd0);
    check("rst_cyc", {24'd0, cyc_cnt}, 32'd0);
    check("rst_stallcnt", {24'd0, stall_cnt}, 32'd0);

    // combinational hazard logic is live while reset is held
    ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
    #1;
    check("rst_lw_stallF", {31'd0, StallF}, 32'd1);
    check("rst_lw_flushE", {31'd0, FlushE}, 32'd1);
    check("rst_lw_stallE", {31'd0, StallE}, 32'd0);
    @(negedge clk);
    check("rst_cyc_hold", {24'd0, cyc_cnt}, 32'd0);
    clear_inputs();
    reset = 1'b1;
    tick();

    // forwarding priority
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd0;
    #1;
    check("fwdA_mem", {30'd0, ForwardAE}, 32'd2);
    check("fwdB_x0", {30'd0, ForwardBE}, 32'd0);
    RdM = 5'd0;
    #1;
    check("fwdA_wb", {30'd0, ForwardAE}, 32'd1);
    RegWriteW = 1'b0;
    #1;
    check("fwdA_none", {30'd0, ForwardAE}, 32'd0);
    RdM = 5'd9; RegWriteM = 1'b1; Rs2E = 5'd9; RegWriteW = 1'b1; RdW = 5'd9;
    #1;
    check("fwdB_mem", {30'd0, ForwardBE}, 32'd2);
    RegWriteM = 1'b0;
    #1;
    check("fwdB_wb", {30'd0, ForwardBE}, 32'd1);
    clear_inputs();

    // load-use stall
    clr_counters();
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    check("lw_stallF", {31'd0, StallF}, 32'd1);
    check("lw_stallD", {31'd0, StallD}, 32'd1);
    check("lw_flushE", {31'd0, FlushE}, 32'd1);
    check("lw_flushD", {31'd0, FlushD}, 32'd0);
    check("lw_stallE", {31'd0, StallE}, 32'd0);
    tick(); tick(); tick();
    check("lw_stallcnt", {24'd0, stall_cnt}, 32'd3);
    check("lw_cyccnt", {24'd0, cyc_cnt}, 32'd3);
    check("lw_flushcnt", {24'd0, flush_cnt}, 32'd0);
    RdE = 5'd0; Rs2D = 5'd0;
    #1;
    check("lw_x0_nostall", {31'd0, StallF}, 32'd0);
    RdE = 5'd7; Rs2D = 5'd7; ResultSrcE = 2'b00;
    #1;
    check("alu_nostall", {31'd0, StallF}, 32'd0);
    clear_inputs();

    // taken branch
    clr_counters();
    PCSrcE = 1'b1;
    #1;
    check("br_flushD", {31'd0, FlushD}, 32'd1);
    check("br_flushE", {31'd0, FlushE}, 32'd1);
    check("br_stallF", {31'd0, StallF}, 32'd0);
    tick(); tick();
    check("br_flushcnt", {24'd0, flush_cnt}, 32'd2);
    clear_inputs();

    // memory wait: ack low three cycles, then high, with a branch pending
    clr_counters();
    MemReqM = 1'b1; MemAckM = 1'b0; PCSrcE = 1'b1;
    #1;
    check("mw0_state", {30'd0, state}, 32'd0);
    check_freeze("mw0", 1'b1);
    check("mw0_flushD", {31'd0, FlushD}, 32'd0);
    check("mw0_flushE", {31'd0, FlushE}, 32'd0);
    tick();
    check("mw1_state", {30'd0, state}, 32'd1);
    check_freeze("mw1", 1'b1);
    tick();
    check("mw2_state", {30'd0, state}, 32'd1);
    check_freeze("mw2", 1'b1);
    check("mw2_flushD", {31'd0, FlushD}, 32'd0);
    tick();
    MemAckM = 1'b1;
    #1;
    check("mw3_state", {30'd0, state}, 32'd1);
    check_freeze("mw3", 1'b0);
    check("mw3_flushD", {31'd0, FlushD}, 32'd1);
    tick();
    check("mw4_state", {30'd0, state}, 32'd0);
    check("mw_cyccnt", {24'd0, cyc_cnt}, 32'd4);
    check("mw_stallcnt", {24'd0, stall_cnt}, 32'd3);
    check("mw_flushcnt", {24'd0, flush_cnt}, 32'd1);
    clear_inputs();

    // request acked in the same cycle: no stall, stays in RUN
    MemReqM = 1'b1; MemAckM = 1'b1;
    #1;
    check("ack_same_stallF", {31'd0, StallF}, 32'd0);
    tick();
    check("ack_same_state", {30'd0, state}, 32'd0);
    clear_inputs();

    // timeout: one RUN cycle, four MEMWAIT cycles, then ERR
    MemReqM = 1'b1;
    tick(); tick(); tick(); tick();
    check("to_state_mw", {30'd0, state}, 32'd1);
    check("to_memerr0", {31'd0, mem_err}, 32'd0);
    tick();
    check("to_state_err", {30'd0, state}, 32'd2);
    check("to_memerr1", {31'd0, mem_err}, 32'd1);
    check_freeze("err", 1'b1);
    MemAckM = 1'b1;
    #1;
    check("err_ack_stallF", {31'd0, StallF}, 32'd1);
    tick();
    check("err_ack_state", {30'd0, state}, 32'd2);
    check("err_ack_memerr", {31'd0, mem_err}, 32'd1);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("err_clr_state", {30'd0, state}, 32'd2);
    MemReqM = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("err_rst_state", {30'd0, state}, 32'd0);
    check("err_rst_memerr", {31'd0, mem_err}, 32'd0);
    check("err_rst_stallF", {31'd0, StallF}, 32'd0);
    reset = 1'b1;
    clear_inputs();
    tick();
    check("post_rst_state", {30'd0, state}, 32'd0);

    // reset mid-MEMWAIT abandons the access
    MemReqM = 1'b1;
    tick();
    check("mid_mw_state", {30'd0, state}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_state", {30'd0, state}, 32'd0);
    check("mid_rst_freeze", {31'd0, StallF}, 32'd1);
    MemReqM = 1'b0;
    reset = 1'b1;
    tick();
    check("mid_rst_run", {30'd0, state}, 32'd0);
    clear_inputs();

    // saturation, then clear overriding a same-cycle increment
    clr_counters();
    ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3; PCSrcE = 1'b1;
    for (int i = 0; i < 260; i++) begin
      tick();
    end
    check("sat_cyc", {24'd0, cyc_cnt}, 32'd255);
    check("sat_stall", {24'd0, stall_cnt}, 32'd255);
    check("sat_flush", {24'd0, flush_cnt}, 32'd255);
    perf_clr = 1'b1;
    #1;
    check("clr_pre_stallF", {31'd0, StallF}, 32'd1);
    check("clr_pre_flushD", {31'd0, FlushD}, 32'd1);
    tick();
    check("clr_cyc", {24'd0, cyc_cnt}, 32'd0);
    check("clr_stall", {24'd0, stall_cnt}, 32'd0);
    check("clr_flush", {24'd0, flush_cnt}, 32'd0);
    perf_clr = 1'b0;
    tick();
    check("clr_resume_cyc", {24'd0, cyc_cnt}, 32'd1);
    check("clr_resume_stall", {24'd0, stall_cnt}, 32'd1);
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
